// File: rtl/fft_bfly_r2_pipe.sv
// ---------------------------------------------------------------------------
// fft_bfly_r2_pipe
//   Streaming radix-2 decimation-in-time butterfly with a 3-stage pipeline:
//     out0 = a + w*b,  out1 = a - w*b
//   S1 registers the four partial products, S2 the rounded complex product,
//   S3 (output register) the scaled or saturated sum/difference.
//   A single stall signal (out_valid & ~out_ready) freezes every stage, so
//   bubbles travel with the data and are never squeezed out.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = ~stall)
//   a_re..b_im            signed DATA_W operands
//   w_re, w_im            signed TW_W twiddle, +1.0 = 2^(TW_W-2)
//   out_valid / out_ready output handshake
//   o0_re..o1_im          a+w*b and a-w*b, signed DATA_W
//   out_last              final butterfly of an N_BFLY-beat frame
//   ovf_sticky / ovf_clr  saturation flag and its synchronous clear
// ---------------------------------------------------------------------------
module fft_bfly_r2_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int SCALE  = 0,
  parameter int N_BFLY = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] o0_re,
  output logic signed [DATA_W-1:0] o0_im,
  output logic signed [DATA_W-1:0] o1_re,
  output logic signed [DATA_W-1:0] o1_im,
  output logic                     out_last,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);

  localparam int PW    = DATA_W + TW_W;   // full product width
  localparam int RW    = DATA_W + 1;      // rounded product width
  localparam int SW    = DATA_W + 2;      // sum/difference width
  localparam int CNT_W = (N_BFLY > 1) ? $clog2(N_BFLY) : 1;

  localparam logic signed [PW:0]       RND   = (PW+1)'(1) << (TW_W - 3);
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(N_BFLY - 1);

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // -------------------------------------------------------------------------
  // S1: delayed a and the four partial products
  // -------------------------------------------------------------------------
  logic                     v1_reg;
  logic signed [DATA_W-1:0] a1_reg [2];
  logic signed [PW-1:0]     rr_reg, ii_reg, ri_reg, ir_reg;

  logic signed [PW-1:0] rr_next, ii_next, ri_next, ir_next;

  assign rr_next = b_re * w_re;
  assign ii_next = b_im * w_im;
  assign ri_next = b_re * w_im;
  assign ir_next = b_im * w_re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      a1_reg[0] <= '0;
      a1_reg[1] <= '0;
      rr_reg    <= '0;
      ii_reg    <= '0;
      ri_reg    <= '0;
      ir_reg    <= '0;
    end else if (adv) begin
      // in_ready == adv, so in_valid alone marks an accepted beat here
      v1_reg    <= in_valid;
      a1_reg[0] <= a_re;
      a1_reg[1] <= a_im;
      rr_reg    <= rr_next;
      ii_reg    <= ii_next;
      ri_reg    <= ri_next;
      ir_reg    <= ir_next;
    end
  end

  // -------------------------------------------------------------------------
  // S2: complex product, rounded half up back to the data scale.
  // One guard bit above PW absorbs the sum of two full-scale products.
  // -------------------------------------------------------------------------
  logic                     v2_reg;
  logic signed [DATA_W-1:0] a2_reg [2];
  logic signed [RW-1:0]     p2_reg [2];

  logic signed [PW:0] pre_re, pre_im;

  assign pre_re = {rr_reg[PW-1], rr_reg} - {ii_reg[PW-1], ii_reg} + RND;
  assign pre_im = {ri_reg[PW-1], ri_reg} + {ir_reg[PW-1], ir_reg} + RND;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_reg    <= 1'b0;
      a2_reg[0] <= '0;
      a2_reg[1] <= '0;
      p2_reg[0] <= '0;
      p2_reg[1] <= '0;
    end else if (adv) begin
      v2_reg    <= v1_reg;
      a2_reg[0] <= a1_reg[0];
      a2_reg[1] <= a1_reg[1];
      // arithmetic shift by TW_W-2 then keep RW bits == this slice
      p2_reg[0] <= pre_re[TW_W-2 +: RW];
      p2_reg[1] <= pre_im[TW_W-2 +: RW];
    end
  end

  // -------------------------------------------------------------------------
  // S3: a +/- p, then halve or clamp. Component order: o0_re, o0_im,
  // o1_re, o1_im; even index = real part, indices 2/3 take the difference.
  // -------------------------------------------------------------------------
  logic                     v3_reg;
  logic signed [DATA_W-1:0] o_reg   [4];
  logic signed [DATA_W-1:0] s3_next [4];
  logic [3:0]               s3_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_comp
      localparam int C = gi % 2;
      logic signed [SW-1:0] a_x;
      logic signed [SW-1:0] p_x;
      logic signed [SW-1:0] pre;

      assign a_x = {{2{a2_reg[C][DATA_W-1]}}, a2_reg[C]};
      assign p_x = {p2_reg[C][RW-1], p2_reg[C]};

      if (gi < 2) begin : g_add
        assign pre = a_x + p_x;
      end else begin : g_sub
        assign pre = a_x - p_x;
      end

      if (SCALE != 0) begin : g_scale
        assign s3_next[gi] = pre[DATA_W:1];
        assign s3_ovf[gi]  = 1'b0;
      end else begin : g_sat
        // in range only when the bits from the DATA_W-1 sign position up agree
        assign s3_ovf[gi]  = ~((&pre[SW-1:DATA_W-1]) | ~(|pre[SW-1:DATA_W-1]));
        assign s3_next[gi] = s3_ovf[gi] ? (pre[SW-1] ? SAT_MIN : SAT_MAX)
                                        : pre[DATA_W-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_reg <= 1'b0;
      for (int i = 0; i < 4; i++) o_reg[i] <= '0;
    end else if (adv) begin
      v3_reg <= v2_reg;
      for (int i = 0; i < 4; i++) o_reg[i] <= s3_next[i];
    end
  end

  assign out_valid = v3_reg;
  assign o0_re     = o_reg[0];
  assign o0_im     = o_reg[1];
  assign o1_re     = o_reg[2];
  assign o1_im     = o_reg[3];

  // -------------------------------------------------------------------------
  // Sticky overflow: a new clamp on a valid beat entering S3 beats the clear
  // -------------------------------------------------------------------------
  logic ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (adv && v2_reg && (|s3_ovf)) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_reg;

  // -------------------------------------------------------------------------
  // Frame position, advanced by completed output transfers only
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (out_valid && out_ready) begin
      cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign out_last = out_valid & (cnt_reg == CNT_LAST);

endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
// ---------------------------------------------------------------------------
// tb_fft_bfly_r2_pipe
//   Three instances share one stimulus:
//     inst 0: SCALE=0, N_BFLY=4   (saturation, frames, backpressure, reset)
//     inst 1: SCALE=1, N_BFLY=4   (halving path)
//     inst 2: SCALE=0, N_BFLY=1   (every beat is last)
//   Directed vectors with hand-computed results, plus hand-written
//   sequences for stall, frame marking and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_fft_bfly_r2_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ovf_clr = 1'b0;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic signed [15:0] w_re = '0, w_im = '0;

  logic               irdy [3];
  logic               ov   [3];
  logic               last [3];
  logic               ovf  [3];
  logic signed [15:0] o0r  [3];
  logic signed [15:0] o0i  [3];
  logic signed [15:0] o1r  [3];
  logic signed [15:0] o1i  [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      fft_bfly_r2_pipe #(
        .DATA_W(16),
        .TW_W  (16),
        .SCALE ((gi == 1) ? 1 : 0),
        .N_BFLY((gi == 2) ? 1 : 4)
      ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (irdy[gi]),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (ov[gi]),
        .out_ready (out_ready),
        .o0_re     (o0r[gi]),
        .o0_im     (o0i[gi]),
        .o1_re     (o1r[gi]),
        .o1_im     (o1i[gi]),
        .out_last  (last[gi]),
        .ovf_sticky(ovf[gi]),
        .ovf_clr   (ovf_clr)
      );
    end
  endgenerate

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_total++;
    if (act != req)
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int a_re, a_im, b_re, b_im, w_re, w_im;
    int e0_re, e0_im, e1_re, e1_im, e_ovf;      // SCALE=0
    int s0_re, s0_im, s1_re, s1_im;             // SCALE=1
  } vec_t;

  vec_t vt [7];

  initial begin
    int sent;
    int got;
    logic stall_prev;
    int held;

    vt[0] = '{100, 0, 50, 0, 16384, 0,        150, 0, 50, 0, 0,      75, 0, 25, 0};
    vt[1] = '{0, 0, 0, 100, 0, -16384,        100, 0, -100, 0, 0,    50, 0, -50, 0};
    vt[2] = '{30000, 0, 30000, 0, 16384, 0,   32767, 0, 0, 0, 1,     30000, 0, 0, 0};
    vt[3] = '{10, 20, 3, 0, 8192, 0,          12, 20, 8, 20, 0,      6, 10, 4, 10};
    vt[4] = '{0, 0, -3, 0, 8192, 0,           -1, 0, 1, 0, 0,        -1, 0, 0, 0};
    vt[5] = '{1000, -2000, 200, 300, 11585, -11585,
              1354, -1929, 646, -2071, 0,     677, -965, 323, -1036};
    vt[6] = '{-30000, -30000, 30000, 30000, -16384, 0,
              -32768, -32768, 0, 0, 1,        -30000, -30000, 0, 0};

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_out_valid", ov[0], 0);
    chk("rst_in_ready", irdy[0], 1);
    chk("rst_o0_re", o0r[0], 0);
    chk("rst_o1_im", o1i[0], 0);
    chk("rst_out_last", last[0], 0);
    chk("rst_out_last_n1", last[2], 0);
    chk("rst_ovf", ovf[0], 0);
    rst = 1'b0;
    tick();

    // ---------------- vector table ----------------
    for (int i = 0; i < 7; i++) begin
      a_re = 16'(vt[i].a_re); a_im = 16'(vt[i].a_im);
      b_re = 16'(vt[i].b_re); b_im = 16'(vt[i].b_im);
      w_re = 16'(vt[i].w_re); w_im = 16'(vt[i].w_im);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int s = 1; s <= 3; s++) begin
        if (s < 3) begin
          chk($sformatf("v%0d_early_valid_c%0d", i, s), ov[0], 0);
          chk($sformatf("v%0d_early_ovf_c%0d", i, s), ovf[0], 0);
          tick();
        end else begin
          chk($sformatf("v%0d_valid", i), ov[0], 1);
          chk($sformatf("v%0d_o0_re", i), o0r[0], vt[i].e0_re);
          chk($sformatf("v%0d_o0_im", i), o0i[0], vt[i].e0_im);
          chk($sformatf("v%0d_o1_re", i), o1r[0], vt[i].e1_re);
          chk($sformatf("v%0d_o1_im", i), o1i[0], vt[i].e1_im);
          chk($sformatf("v%0d_ovf", i), ovf[0], vt[i].e_ovf);
          chk($sformatf("v%0d_sc_o0_re", i), o0r[1], vt[i].s0_re);
          chk($sformatf("v%0d_sc_o0_im", i), o0i[1], vt[i].s0_im);
          chk($sformatf("v%0d_sc_o1_re", i), o1r[1], vt[i].s1_re);
          chk($sformatf("v%0d_sc_o1_im", i), o1i[1], vt[i].s1_im);
          chk($sformatf("v%0d_sc_ovf", i), ovf[1], 0);
          chk($sformatf("v%0d_n1_last", i), last[2], 1);
        end
      end
      tick();
      chk($sformatf("v%0d_drain", i), ov[0], 0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk($sformatf("v%0d_ovf_clr", i), ovf[0], 0);
    end

    // ---------------- backpressure ----------------
    do_reset();
    b_re = '0; b_im = '0; w_re = '0; w_im = '0; a_im = '0;
    sent = 0; got = 0; stall_prev = 1'b0; held = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      in_valid  = (sent < 6);
      a_re      = 16'(sent + 1);
      out_ready = !(c >= 4 && c <= 7);
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), irdy[0], int'(!(ov[0] && !out_ready)));
      if (stall_prev) begin
        chk($sformatf("bp_hold_valid_c%0d", c), ov[0], 1);
        chk($sformatf("bp_hold_data_c%0d", c), o0r[0], held);
      end
      if (ov[0] && out_ready) begin
        chk($sformatf("bp_order_o0_%0d", got), o0r[0], got + 1);
        chk($sformatf("bp_order_o1_%0d", got), o1r[0], got + 1);
        got++;
      end
      stall_prev = ov[0] && !out_ready;
      held = o0r[0];
      if (in_valid && irdy[0]) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 6);
    tick();
    chk("bp_no_dup", ov[0], 0);

    // ---------------- frames, N_BFLY=4 ----------------
    do_reset();
    sent = 0; got = 0;
    for (int c = 0; c < 20 && got < 12; c++) begin
      in_valid = (sent < 12);
      a_re = 16'(sent);
      #1;
      if (ov[0]) begin
        chk($sformatf("frame_last_%0d", got), last[0], int'(got % 4 == 3));
        chk($sformatf("frame_data_%0d", got), o0r[0], got);
        got++;
      end else begin
        chk($sformatf("frame_idle_last_c%0d", c), last[0], 0);
      end
      chk($sformatf("frame_n1_last_c%0d", c), last[2], int'(ov[2]));
      if (in_valid) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("frame_count", got, 12);

    // ---------------- reset mid-stream ----------------
    do_reset();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a_re = 16'(100 + c);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", ov[0], 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_ready", irdy[0], 1);
    chk("mid_rst_data", o0r[0], 0);
    tick();
    rst = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got < 4; c++) begin
      in_valid = (c < 4);
      a_re = 16'(10 + c);
      #1;
      if (c < 3) chk($sformatf("mid_lat_c%0d", c), ov[0], 0);
      if (c == 3) chk("mid_lat_c3", ov[0], 1);
      if (ov[0]) begin
        chk($sformatf("mid_data_%0d", got), o0r[0], 10 + got);
        chk($sformatf("mid_last_%0d", got), last[0], int'(got == 3));
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("mid_count", got, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
